// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit RISC-V pipeline: sized loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding and feeds bubbles to MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] aluResult_in,
    input  logic [63:0] storeData_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    output logic [63:0] aluResult_out,
    output logic [63:0] memData_out,
    output logic [4:0]  rd_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        stall_out,
    output logic        fault_out,
    mem_access_stage_if.master dmem
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CntWidth-1:0] waitCnt;
    logic [63:0]         rdLatch;
    logic                errFlag;

    logic        memop;
    logic        isStore;
    logic        isLoad;
    logic [1:0]  sizeSel;
    logic [2:0]  byteOff;
    logic        illegalSize;
    logic        misaligned;
    logic        bad;
    logic        timedOut;
    logic [7:0]  sizeMask;
    logic [63:0] shifted;
    logic [63:0] loadExt;

    // A store wins when both MemRead and MemWrite are set.
    assign memop       = MemRead_in | MemWrite_in;
    assign isStore     = MemWrite_in;
    assign isLoad      = MemRead_in & ~MemWrite_in;
    assign sizeSel     = funct3_in[1:0];
    assign byteOff     = aluResult_in[2:0];
    assign illegalSize = isLoad && (funct3_in == 3'b111);
    assign bad         = illegalSize | misaligned;
    assign timedOut    = (TIMEOUT != 0) && ((32'(waitCnt) + 32'd1) >= TIMEOUT);

    always_comb begin
        misaligned = 1'b0;
        sizeMask   = 8'h01;
        case (sizeSel)
            2'b00: begin misaligned = 1'b0;          sizeMask = 8'h01; end
            2'b01: begin misaligned = byteOff[0];    sizeMask = 8'h03; end
            2'b10: begin misaligned = |byteOff[1:0]; sizeMask = 8'h0F; end
            default: begin misaligned = |byteOff;    sizeMask = 8'hFF; end
        endcase
    end

    // Bus payload follows the inputs, which the stall keeps stable during BUSY.
    assign dmem.dmem_we    = isStore;
    assign dmem.dmem_addr  = {aluResult_in[63:3], 3'b000};
    assign dmem.dmem_wdata = storeData_in << {byteOff, 3'b000};
    assign dmem.dmem_wstrb = isStore ? (sizeMask << byteOff) : 8'h00;

    assign shifted = rdLatch >> {byteOff, 3'b000};

    always_comb begin
        loadExt = 64'h0;
        case (funct3_in)
            3'b000:  loadExt = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  loadExt = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  loadExt = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  loadExt = shifted;
            3'b100:  loadExt = {56'h0, shifted[7:0]};
            3'b101:  loadExt = {48'h0, shifted[15:0]};
            3'b110:  loadExt = {32'h0, shifted[31:0]};
            default: loadExt = 64'h0;
        endcase
    end

    // Access sequencer; DONE always returns to IDLE so an instruction issues once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            waitCnt       <= '0;
            rdLatch       <= 64'h0;
            errFlag       <= 1'b0;
            dmem.dmem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop && !bad) begin
                        state         <= BUSY;
                        waitCnt       <= '0;
                        errFlag       <= 1'b0;
                        dmem.dmem_req <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        if (isLoad) rdLatch <= dmem.dmem_rdata;
                        dmem.dmem_req <= 1'b0;
                        state         <= DONE;
                    end else if (timedOut) begin
                        dmem.dmem_req <= 1'b0;
                        errFlag       <= 1'b1;
                        state         <= DONE;
                    end else if (waitCnt != '1) begin
                        waitCnt <= waitCnt + CntWidth'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB feed: pass-through, bubble while stalled, result in DONE.
    always_comb begin
        aluResult_out = aluResult_in;
        memData_out   = 64'h0;
        rd_out        = rd_in;
        MemtoReg_out  = MemtoReg_in;
        RegWrite_out  = RegWrite_in;
        stall_out     = 1'b0;
        fault_out     = 1'b0;
        case (state)
            IDLE: begin
                if (memop && bad) begin
                    fault_out    = ~reset;
                    RegWrite_out = 1'b0;
                end else if (memop) begin
                    stall_out     = ~reset;
                    aluResult_out = 64'h0;
                    rd_out        = 5'd0;
                    MemtoReg_out  = 1'b0;
                    RegWrite_out  = 1'b0;
                end
            end
            BUSY: begin
                stall_out     = 1'b1;
                aluResult_out = 64'h0;
                rd_out        = 5'd0;
                MemtoReg_out  = 1'b0;
                RegWrite_out  = 1'b0;
            end
            DONE: begin
                memData_out = loadExt;
                if (errFlag) begin
                    fault_out    = 1'b1;
                    RegWrite_out = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Vector table with a scoreboard queue and a small in-bench memory responder.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] aluResult_in, storeData_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
    logic [63:0] aluResult_out, memData_out;
    logic [4:0]  rd_out;
    logic        MemtoReg_out, RegWrite_out, stall_out, fault_out;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .aluResult_in(aluResult_in), .storeData_in(storeData_in), .rd_in(rd_in),
        .funct3_in(funct3_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .aluResult_out(aluResult_out), .memData_out(memData_out), .rd_out(rd_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .stall_out(stall_out), .fault_out(fault_out),
        .dmem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] alu, sdata;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, m2r, rw;
        int          ackDelay;
        logic [63:0] rdata;
        int          expStall, expReq;
        logic        chkMem;
        logic [63:0] expMem;
        logic        expRw, expFault, expWe;
        logic [63:0] expAddr, expWdata;
        logic [7:0]  expStrb;
    } vec_t;

    vec_t vecs[14];
    vec_t sb[$];
    int   nVec = 0;
    int   nMis = 0;

    function automatic vec_t mk(string n, logic [63:0] a, logic [63:0] s, logic [4:0] r,
                                logic [2:0] f, logic mr, logic mw, logic m2r, logic rw,
                                int dly, logic [63:0] rdat, int eStall, int eReq,
                                logic chkM, logic [63:0] eMem, logic eRw, logic eFault,
                                logic eWe, logic [63:0] eAddr, logic [63:0] eWdata,
                                logic [7:0] eStrb);
        vec_t v;
        v.name = n; v.alu = a; v.sdata = s; v.rd = r; v.f3 = f;
        v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
        v.ackDelay = dly; v.rdata = rdat; v.expStall = eStall; v.expReq = eReq;
        v.chkMem = chkM; v.expMem = eMem; v.expRw = eRw; v.expFault = eFault;
        v.expWe = eWe; v.expAddr = eAddr; v.expWdata = eWdata; v.expStrb = eStrb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v);
        int          stallCyc, reqCyc, bubbleBad;
        bit          done;
        logic [63:0] cAddr, cWdata;
        logic [7:0]  cStrb;
        logic        cWe;
        vec_t        e;
        @(negedge clk);
        aluResult_in = v.alu; storeData_in = v.sdata; rd_in = v.rd; funct3_in = v.f3;
        MemRead_in = v.mr; MemWrite_in = v.mw; MemtoReg_in = v.m2r; RegWrite_in = v.rw;
        bus.dmem_ack = 1'b0;
        sb.push_back(v);
        stallCyc = 0; reqCyc = 0; bubbleBad = 0; done = 1'b0;
        cAddr = 64'h0; cWdata = 64'h0; cStrb = 8'h0; cWe = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            bus.dmem_ack = 1'b0;
            if (stall_out) begin
                stallCyc++;
                if (RegWrite_out || MemtoReg_out || rd_out != 5'd0 || aluResult_out != 64'h0 ||
                    memData_out != 64'h0 || fault_out)
                    bubbleBad++;
                if (bus.dmem_req) begin
                    if (reqCyc == 0) begin
                        cAddr = bus.dmem_addr; cWdata = bus.dmem_wdata;
                        cStrb = bus.dmem_wstrb; cWe = bus.dmem_we;
                    end
                    if (reqCyc == v.ackDelay) begin
                        bus.dmem_ack   = 1'b1;
                        bus.dmem_rdata = v.rdata;
                    end
                    reqCyc++;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
                e = sb.pop_front();
                chk({e.name, ".stall"},    64'(stallCyc),    64'(e.expStall));
                chk({e.name, ".reqcyc"},   64'(reqCyc),      64'(e.expReq));
                chk({e.name, ".reqdone"},  64'(bus.dmem_req), 64'h0);
                chk({e.name, ".bubble"},   64'(bubbleBad),   64'h0);
                chk({e.name, ".alu"},      aluResult_out,    e.alu);
                chk({e.name, ".rd"},       64'(rd_out),      64'(e.rd));
                chk({e.name, ".memtoreg"}, 64'(MemtoReg_out), 64'(e.m2r));
                chk({e.name, ".regwrite"}, 64'(RegWrite_out), 64'(e.expRw));
                chk({e.name, ".fault"},    64'(fault_out),   64'(e.expFault));
                if (e.chkMem) chk({e.name, ".memdata"}, memData_out, e.expMem);
                if (e.expReq > 0) begin
                    chk({e.name, ".addr"},  cAddr,      e.expAddr);
                    chk({e.name, ".wdata"}, cWdata,     e.expWdata);
                    chk({e.name, ".wstrb"}, 64'(cStrb), 64'(e.expStrb));
                    chk({e.name, ".we"},    64'(cWe),   64'(e.expWe));
                end
            end
        end
        if (!done) begin
            e = sb.pop_front();
            chk({e.name, ".completed"}, 64'h0, 64'h1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("add",    64'h1234, 64'h0, 5'd5, 3'b000, 0,0,0,1, -1, 64'h0,
                      0, 0, 1, 64'h0, 1,0,0, 64'h0, 64'h0, 8'h00);
        vecs[1]  = mk("lb",     64'h1003, 64'h0, 5'd7, 3'b000, 1,0,1,1, 0, 64'h0000_0000_8000_0000,
                      2, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 1,0,0, 64'h1000, 64'h0, 8'h00);
        vecs[2]  = mk("lbu",    64'h1003, 64'h0, 5'd7, 3'b100, 1,0,1,1, 0, 64'h0000_0000_8000_0000,
                      2, 1, 1, 64'h80, 1,0,0, 64'h1000, 64'h0, 8'h00);
        vecs[3]  = mk("sh",     64'h2002, 64'hABCD, 5'd3, 3'b001, 0,1,0,0, 3, 64'h0,
                      5, 4, 0, 64'h0, 0,0,1, 64'h2000, 64'h0000_0000_ABCD_0000, 8'h0C);
        vecs[4]  = mk("lw_mis", 64'h3002, 64'h0, 5'd9, 3'b010, 1,0,1,1, -1, 64'h0,
                      0, 0, 1, 64'h0, 0,1,0, 64'h0, 64'h0, 8'h00);
        vecs[5]  = mk("ld_ill", 64'h3000, 64'h0, 5'd9, 3'b111, 1,0,1,1, -1, 64'h0,
                      0, 0, 1, 64'h0, 0,1,0, 64'h0, 64'h0, 8'h00);
        vecs[6]  = mk("ld_to",  64'h4000, 64'h0, 5'd10, 3'b011, 1,0,1,1, -1, 64'h0,
                      17, 16, 0, 64'h0, 0,1,0, 64'h4000, 64'h0, 8'h00);
        vecs[7]  = mk("ld",     64'h5008, 64'h0, 5'd11, 3'b011, 1,0,1,1, 1, 64'h1122_3344_5566_7788,
                      3, 2, 1, 64'h1122_3344_5566_7788, 1,0,0, 64'h5008, 64'h0, 8'h00);
        vecs[8]  = mk("lh",     64'h6006, 64'h0, 5'd12, 3'b001, 1,0,1,1, 0, 64'h8001_0000_0000_0000,
                      2, 1, 1, 64'hFFFF_FFFF_FFFF_8001, 1,0,0, 64'h6000, 64'h0, 8'h00);
        vecs[9]  = mk("lwu",    64'h7004, 64'h0, 5'd13, 3'b110, 1,0,1,1, 2, 64'h89AB_CDEF_0000_0000,
                      4, 3, 1, 64'h0000_0000_89AB_CDEF, 1,0,0, 64'h7000, 64'h0, 8'h00);
        vecs[10] = mk("sd_rw",  64'h8000, 64'h0123_4567_89AB_CDEF, 5'd0, 3'b011, 1,1,0,0, 0, 64'h0,
                      2, 1, 0, 64'h0, 0,0,1, 64'h8000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        vecs[11] = mk("sb",     64'h9005, 64'h5A, 5'd0, 3'b000, 0,1,0,0, 1, 64'h0,
                      3, 2, 0, 64'h0, 0,0,1, 64'h9000, 64'h0000_5A00_0000_0000, 8'h20);
        vecs[12] = mk("sw_mis", 64'hA001, 64'h1, 5'd4, 3'b010, 0,1,0,1, -1, 64'h0,
                      0, 0, 1, 64'h0, 0,1,0, 64'h0, 64'h0, 8'h00);
        vecs[13] = mk("pass",   64'hDEAD, 64'h0, 5'd31, 3'b000, 0,0,0,1, -1, 64'h0,
                      0, 0, 1, 64'h0, 1,0,0, 64'h0, 64'h0, 8'h00);

        reset = 1'b1;
        aluResult_in = 64'h0; storeData_in = 64'h0; rd_in = 5'd0; funct3_in = 3'b000;
        MemRead_in = 1'b0; MemWrite_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 64'h0;
        #12;
        chk("rst.req",   64'(bus.dmem_req), 64'h0);
        chk("rst.stall", 64'(stall_out),    64'h0);
        chk("rst.fault", 64'(fault_out),    64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) runVec(vecs[i]);

        // Reset in the middle of an outstanding load.
        @(negedge clk);
        aluResult_in = 64'hB000; funct3_in = 3'b011; rd_in = 5'd14;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; MemtoReg_in = 1'b1; RegWrite_in = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst.req_before",   64'(bus.dmem_req), 64'h1);
        chk("midrst.stall_before", 64'(stall_out),    64'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrst.req",   64'(bus.dmem_req), 64'h0);
        chk("midrst.stall", 64'(stall_out),    64'h0);
        chk("midrst.fault", 64'(fault_out),    64'h0);
        MemRead_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        runVec(mk("ld_after_rst", 64'hC000, 64'h0, 5'd15, 3'b011, 1,0,1,1, 0, 64'h0000_0000_0000_CAFE,
                  2, 1, 1, 64'h0000_0000_0000_CAFE, 1,0,0, 64'hC000, 64'h0, 8'h00));

        chk("sb.empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 64-bit 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs loads and stores of byte, half, word and double-word size over a req/ack data-memory bus, and holds the upstream pipeline while an access is outstanding.
- Produces the ALU-result, load-data, rd and control values captured by the MEM/WB register. That register has no enable, so this block inserts bubbles itself.

Parameters:
- TIMEOUT, 16, maximum cycles dmem_req stays high without dmem_ack before the access aborts; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- aluResult_in  in  64  effective address for memory ops, otherwise the ALU result
- storeData_in  in  64  rs2 value for stores
- rd_in  in  5  destination register
- funct3_in  in  3  access size/sign
- MemRead_in  in  1  load
- MemWrite_in  in  1  store
- MemtoReg_in  in  1  writeback select
- RegWrite_in  in  1  writeback enable
- aluResult_out  out  64  to MEM/WB
- memData_out  out  64  extended load data to MEM/WB
- rd_out  out  5  to MEM/WB
- MemtoReg_out  out  1  to MEM/WB
- RegWrite_out  out  1  to MEM/WB
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- fault_out  out  1  one-cycle pulse: misaligned, illegal size, or bus timeout
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  64  {aluResult_in[63:3],3'b000}
- dmem_wdata  out  64  storeData_in shifted left by 8*addr[2:0]
- dmem_wstrb  out  8  byte enables
- dmem_rdata  in  64  read data, valid with ack
- dmem_ack  in  1  completes the request

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. Reset forces state IDLE, timeout counter 0, read-data latch 0, dmem_req 0, fault_out 0. stall_out goes to 0 immediately, including mid-access; the pending access is abandoned.
- Operation select:
  - memop = MemRead_in | MemWrite_in. If both are set, treat it as a store.
  - funct3 sizes: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU. Value 111 is illegal.
  - Stores use only the size bits, funct3[1:0].
- bad = illegal size, or misaligned address: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.
- Byte strobes: wstrb = size mask (0x01, 0x03, 0x0F, 0xFF) << addr[2:0]. dmem_wstrb = 0 for loads.
- States:
  - IDLE:
    - No memop: pass all inputs straight through combinationally, memData_out = 0, stall_out 0.
    - memop and bad: no bus access; fault_out = 1 this cycle; RegWrite_out = 0; stall_out 0; stay in IDLE.
    - memop and good: stall_out = 1; bubble to MEM/WB; next state BUSY.
  - BUSY:
    - dmem_req = 1 (registered, first high in the cycle after IDLE).
    - dmem_we, addr, wdata and wstrb are held from inputs, which are stable because of the stall.
    - stall_out = 1; bubble out.
    - On dmem_ack: latch dmem_rdata (loads only) and go to DONE. dmem_req drops the cycle after ack.
    - If the counter reaches TIMEOUT without ack: drop req, set the err flag, go to DONE.
  - DONE:
    - stall_out = 0; outputs take the input values.
    - memData_out = latched data >> 8*addr[2:0], sign-extended (B/H/W) or zero-extended (BU/HU/WU/D) from the access size.
    - If err: fault_out = 1 and RegWrite_out = 0.
    - Next state IDLE unconditionally, so the same instruction is never re-issued.
- Bubble: RegWrite_out = 0, MemtoReg_out = 0, rd_out = 0, aluResult_out = 0, memData_out = 0.
- Latency:
  - Non-memory ops: 0 extra cycles.
  - Good memory op: 2 + ack wait cycles of stall. With ack in the first BUSY cycle the op is at MEM/WB 3 cycles after reaching the stage.
- The timeout counter clears on entry to BUSY and saturates.
- dmem_ack outside BUSY is ignored.

Test Plan:
- ADD with aluResult_in = 0x1234, rd = 5, RegWrite = 1 → same-cycle pass-through; stall_out 0; no dmem_req.
- LB at addr 0x1003, ack in first BUSY cycle with rdata = 0x00000000_80000000 → stall high 2 cycles; dmem_addr 0x1000; memData_out = 0xFFFFFFFF_FFFFFF80 in DONE; LBU of the same gives 0x80.
- SH at addr 0x2002, storeData = 0xABCD, ack after 3 wait cycles → dmem_wstrb = 0x0C; dmem_wdata[31:16] = 0xABCD; dmem_req high 4 cycles; RegWrite_out 0 throughout the stall.
- LW at addr 0x3002 → no dmem_req; fault_out single pulse; RegWrite_out 0; stall_out 0. Repeat with funct3 = 111 and get the same result.
- LD with TIMEOUT = 16 and no ack → req high 16 cycles, then DONE with fault_out pulse and RegWrite_out 0; pipeline resumes.
- Assert reset during BUSY → dmem_req and stall_out drop asynchronously; state IDLE; a new LD after reset completes normally.
